ssram_arb: RTL and testbench
============================

# ssram_arb

Parametrised synchronous SRAM with two independent request channels (A: CPU bus side, B: QOI engine/DMA side) sharing one single-ported storage array. It replaces the bidirectional-bus SSRAM with split read/write data, byte enables, a req/gnt handshake with round-robin arbitration, and a configurable read pipeline. It sits between the 6502 bus glue and the QOI codec, which both need access to the same pixel/scratch memory.

## Interface
- ADDR_WIDTH, 10, address bits per channel
- DATA_WIDTH, 8, word width; must be a multiple of 8
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH
- READ_LATENCY, 1, cycles from accept edge to rvalid; legal values 1 or 2
- BE_WIDTH, DATA_WIDTH/8, derived; not to be overridden
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  channel request; held until granted
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_WIDTH  word address
- a_wdata / b_wdata  in  DATA_WIDTH  write data
- a_be / b_be  in  BE_WIDTH  byte enables for writes (bit i -> bits 8i+7:8i); ignored on reads
- a_gnt / b_gnt  out  1  combinational grant; access accepted on edge where req & gnt
- a_rvalid / b_rvalid  out  1  one-cycle pulse: rdata valid
- a_rdata / b_rdata  out  DATA_WIDTH  read data; holds last value between reads

## Operation
- At most one array access per cycle.
- Arbitration: only one req -> grant it. Both req -> grant the channel not granted most recently (rr pointer, 1 bit). Pointer updates only on an accepted access. Reset value of pointer favours A.
- Write accept: bytes with be=1 updated at the accept edge; be=0 bytes unchanged; be=0 overall is a legal no-op write (still consumes the cycle, moves pointer). No rvalid for writes.
- Read accept: word at addr returned on the issuing channel's rdata with rvalid; the other channel's rvalid/rdata unaffected.
- Address >= DEPTH: write ignored; read returns all zeros with normal rvalid timing.
- Read of a word written on an earlier edge returns the new data (no stale read). Same-cycle read/write collision cannot occur.
- Memory contents are not reset and not initialised.
- Reset asserted: gnt = 0, rvalid = 0, rdata = 0, pointer = A, in-flight reads discarded (no rvalid after release). Async assertion; release synchronous to clk by upstream.

## Timing
- gnt is combinational from req, rr pointer and rst_n; no wait state when uncontended.
- READ_LATENCY=1: rvalid/rdata asserted in the cycle after the accept edge.
- READ_LATENCY=2: one extra output register stage; rvalid in the second cycle after accept.
- Throughput: one access per cycle total; back-to-back reads on one channel return back-to-back rvalids in order.
- Under continuous contention A and B alternate strictly: A, B, A, B...
- Reset values: a_gnt, b_gnt, a_rvalid, b_rvalid = 0; a_rdata, b_rdata = 0.

## Structure
- Shared package ssram_pkg: channel index constants (CH_A=0, CH_B=1), READ_LATENCY legality check helper, BE_WIDTH derivation function.
- Sub-module ssram_array: plain single-port synchronous array (addr, wdata, be, we, en, rdata registered), no reset; ssram_arb holds arbiter, read-tag pipeline (valid + channel id per stage), output registers and range check.
- Elaboration-time error if DATA_WIDTH % 8 != 0, DEPTH > 2**ADDR_WIDTH, or READ_LATENCY not in {1,2}.

## Test plan
- DATA_WIDTH=16, LAT=1: A writes 0xBEEF to 0x010 be=11, then A reads 0x010 -> a_rvalid one cycle after accept, a_rdata=0xBEEF, b_rvalid stays 0.
- Byte enables: write 0x1234 to 0x020, then write 0xABCD be=01 -> read returns 0x12CD.
- Contention: a_req and b_req held high 6 cycles on reads of 0x001/0x002 -> grants A,B,A,B,A,B; each rvalid on correct channel with correct data.
- LAT=2, B issues reads 0x003,0x004,0x005 back-to-back -> b_rvalid high for 3 consecutive cycles starting 2 cycles after first accept, data in order.
- DEPTH=1000, ADDR_WIDTH=10: write 0x55 to 1010 then read 1010 -> rdata 0x00 with rvalid; word 0 unchanged.
- Read accepted, rst_n pulsed low mid-pipeline -> no rvalid after release, all outputs 0, next contended request grants A first.

Source files
------------

// File: rtl/ssram_pkg.sv
// Shared definitions for the dual-channel SSRAM: channel ids and parameter helpers.
package ssram_pkg;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  function automatic bit lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ssram_array.sv
// Plain single-port synchronous storage with byte-enable writes and a registered read port.
module ssram_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]      idx;

  assign idx   = addr[IDX_W-1:0];
  assign rdata = rdata_q;

  // Caller guarantees en is only raised for in-range addresses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/ssram_arb.sv
// Two-channel SSRAM front end: round-robin arbiter, range check, read-tag pipeline
// and per-channel read data holding registers around a single-port array.
module ssram_arb
  import ssram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int BE_WIDTH     = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [BE_WIDTH-1:0]   a_be,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [BE_WIDTH-1:0]   b_be,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  if ((DATA_WIDTH % 8 != 0) || (DATA_WIDTH < 8)) begin : g_bad_dw
    $error("ssram_arb: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("ssram_arb: DEPTH exceeds address space");
  end
  if (!lat_ok(READ_LATENCY)) begin : g_bad_lat
    $error("ssram_arb: READ_LATENCY must be 1 or 2");
  end
  if (BE_WIDTH != DATA_WIDTH / 8) begin : g_bad_be
    $error("ssram_arb: BE_WIDTH must not be overridden");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  logic                  rr_q, rr_d;
  logic                  v1_q, v1_d, ch1_q, ch1_d, oor1_q, oor1_d;
  logic [DATA_WIDTH-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;

  logic                  acc, sel_b, in_range, mem_en;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata, arr_rdata, s1_d;
  logic [BE_WIDTH-1:0]   acc_be;
  logic                  fin_v, fin_ch;
  logic [DATA_WIDTH-1:0] fin_d;

  // rr_q names the channel that wins the next tie.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      a_gnt = a_req & (~b_req | (rr_q == CH_A));
      b_gnt = b_req & ~a_gnt;
    end
  end

  always_comb begin
    sel_b     = b_gnt;
    acc       = a_gnt | b_gnt;
    acc_we    = sel_b ? b_we    : a_we;
    acc_addr  = sel_b ? b_addr  : a_addr;
    acc_wdata = sel_b ? b_wdata : a_wdata;
    acc_be    = sel_b ? b_be    : a_be;
    in_range  = ({1'b0, acc_addr} < DEPTH_LIM);
    mem_en    = acc & in_range;

    rr_d = rr_q;
    if (acc) rr_d = sel_b ? CH_A : CH_B;

    v1_d   = acc & ~acc_we;
    ch1_d  = sel_b;
    oor1_d = ~in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= CH_A;
      v1_q   <= 1'b0;
      ch1_q  <= CH_A;
      oor1_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      v1_q   <= v1_d;
      ch1_q  <= ch1_d;
      oor1_q <= oor1_d;
    end
  end

  ssram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (acc_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (arr_rdata)
  );

  // Out-of-range reads never touched the array, so their stale output is masked.
  assign s1_d = oor1_q ? '0 : arr_rdata;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2_q, v2_d, ch2_q, ch2_d;
    logic [DATA_WIDTH-1:0] d2_q, d2_d;

    always_comb begin
      v2_d  = v1_q;
      ch2_d = ch1_q;
      d2_d  = v1_q ? s1_d : d2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q  <= 1'b0;
        ch2_q <= CH_A;
        d2_q  <= '0;
      end else begin
        v2_q  <= v2_d;
        ch2_q <= ch2_d;
        d2_q  <= d2_d;
      end
    end

    assign fin_v  = v2_q;
    assign fin_ch = ch2_q;
    assign fin_d  = d2_q;
  end else begin : g_lat1
    assign fin_v  = v1_q;
    assign fin_ch = ch1_q;
    assign fin_d  = s1_d;
  end

  always_comb begin
    a_rvalid = fin_v & (fin_ch == CH_A);
    b_rvalid = fin_v & (fin_ch == CH_B);
    a_rdata  = a_rvalid ? fin_d : a_hold_q;
    b_rdata  = b_rvalid ? fin_d : b_hold_q;
    a_hold_d = a_rdata;
    b_hold_d = b_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      a_hold_q <= a_hold_d;
      b_hold_q <= b_hold_d;
    end
  end

endmodule

// File: tb/tb_ssram_arb.sv
// Drives a latency-1 and a latency-2 ssram_arb with identical traffic and checks both
// against a word-array memory model with a simple turn-taking arbiter model.
module tb_ssram_arb;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1000;
  localparam int BW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic [BW-1:0] a_be = '0, b_be = '0;

  logic          a_gnt1, b_gnt1, a_rvalid1, b_rvalid1;
  logic [DW-1:0] a_rdata1, b_rdata1;
  logic          a_gnt2, b_gnt2, a_rvalid2, b_rvalid2;
  logic [DW-1:0] a_rdata2, b_rdata2;

  ssram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1)
  );

  ssram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_gnt(a_gnt2), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_gnt(b_gnt2), .b_rvalid(b_rvalid2), .b_rdata(b_rdata2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  typedef struct packed {
    logic          valid;
    logic          ch;
    logic [DW-1:0] data;
  } rec_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [DEPTH];
  rec_t          s1, s2;
  logic [DW-1:0] hold1 [2];
  logic [DW-1:0] hold2 [2];
  logic          turn_b;
  logic          g_a, g_b, obs_ga1;
  req_t          pa, pb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    s1 = '0;
    s2 = '0;
    hold1[0] = '0; hold1[1] = '0;
    hold2[0] = '0; hold2[1] = '0;
    turn_b = 1'b0;
  endtask

  function automatic req_t rd(input logic [AW-1:0] addr);
    req_t r;
    r = '0;
    r.req  = 1'b1;
    r.addr = addr;
    return r;
  endfunction

  function automatic req_t wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_t r;
    r.req   = 1'b1;
    r.we    = 1'b1;
    r.addr  = addr;
    r.wdata = d;
    r.be    = be;
    return r;
  endfunction

  task automatic check_output();
    if (s1.valid) hold1[s1.ch] = s1.data;
    if (s2.valid) hold2[s2.ch] = s2.data;
    check("a_rvalid1", a_rvalid1, s1.valid && !s1.ch);
    check("b_rvalid1", b_rvalid1, s1.valid && s1.ch);
    check("a_rdata1",  a_rdata1,  hold1[0]);
    check("b_rdata1",  b_rdata1,  hold1[1]);
    check("a_rvalid2", a_rvalid2, s2.valid && !s2.ch);
    check("b_rvalid2", b_rvalid2, s2.valid && s2.ch);
    check("a_rdata2",  a_rdata2,  hold2[0]);
    check("b_rdata2",  b_rdata2,  hold2[1]);
  endtask

  task automatic apply_stimulus(input req_t ra, input req_t rb, output logic ga, output logic gb);
    req_t cur;
    rec_t nr;
    @(negedge clk);
    a_req = ra.req; a_we = ra.we; a_addr = ra.addr; a_wdata = ra.wdata; a_be = ra.be;
    b_req = rb.req; b_we = rb.we; b_addr = rb.addr; b_wdata = rb.wdata; b_be = rb.be;
    #1;
    ga = ra.req && (!rb.req || !turn_b);
    gb = rb.req && !ga;
    obs_ga1 = a_gnt1;
    check("a_gnt1", a_gnt1, ga);
    check("b_gnt1", b_gnt1, gb);
    check("a_gnt2", a_gnt2, ga);
    check("b_gnt2", b_gnt2, gb);
    @(posedge clk);
    nr = '0;
    if (ga || gb) begin
      cur    = ga ? ra : rb;
      turn_b = ga;
      if (cur.we) begin
        if (int'(cur.addr) < DEPTH) begin
          for (int i = 0; i < BW; i++) begin
            if (cur.be[i]) mem_m[cur.addr][8*i +: 8] = cur.wdata[8*i +: 8];
          end
        end
      end else begin
        nr.valid = 1'b1;
        nr.ch    = gb;
        nr.data  = (int'(cur.addr) < DEPTH) ? mem_m[cur.addr] : '0;
      end
    end
    s2 = s1;
    s1 = nr;
    #1;
    check_output();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] ad;
    model_reset();

    // Reset state with both requests raised: grants must stay low.
    a_req = 1'b1; b_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_gnt1", a_gnt1, 1'b0);
    check("rst_b_gnt1", b_gnt1, 1'b0);
    check("rst_a_gnt2", a_gnt2, 1'b0);
    check_output();
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 58; i++) begin
      ad = (i < 48) ? AW'(i) : AW'(990 + i - 48);
      d  = DW'($urandom);
      if (i % 2 == 0) apply_stimulus(wr(ad, d, 2'b11), '0, g_a, g_b);
      else            apply_stimulus('0, wr(ad, d, 2'b11), g_a, g_b);
    end

    $display("[TB] basic write/read");
    apply_stimulus(wr(10'h010, 16'hBEEF, 2'b11), '0, g_a, g_b);
    apply_stimulus(rd(10'h010), '0, g_a, g_b);
    check("beef_data", a_rdata1, 16'hBEEF);
    check("beef_valid", a_rvalid1, 1'b1);
    check("beef_b_quiet", b_rvalid1, 1'b0);
    apply_stimulus('0, '0, g_a, g_b);
    check("beef_data_lat2", a_rdata2, 16'hBEEF);

    $display("[TB] byte enables");
    apply_stimulus(wr(10'h020, 16'h1234, 2'b11), '0, g_a, g_b);
    apply_stimulus(wr(10'h020, 16'hABCD, 2'b01), '0, g_a, g_b);
    apply_stimulus(rd(10'h020), '0, g_a, g_b);
    check("be_merge", a_rdata1, 16'h12CD);
    apply_stimulus('0, '0, g_a, g_b);

    $display("[TB] reset mid-pipeline");
    apply_stimulus(rd(10'h010), '0, g_a, g_b);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_a_gnt1", a_gnt1, 1'b0);
    check("mid_rst_a_gnt2", a_gnt2, 1'b0);
    check_output();
    @(negedge clk) a_req = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) apply_stimulus('0, '0, g_a, g_b);

    $display("[TB] contention");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(rd(10'h001), rd(10'h002), g_a, g_b);
      check("rr_alternate", obs_ga1, (i % 2) == 0);
    end
    repeat (2) apply_stimulus('0, '0, g_a, g_b);

    $display("[TB] back-to-back reads on B");
    apply_stimulus('0, rd(10'h003), g_a, g_b);
    apply_stimulus('0, rd(10'h004), g_a, g_b);
    apply_stimulus('0, rd(10'h005), g_a, g_b);
    repeat (3) apply_stimulus('0, '0, g_a, g_b);

    $display("[TB] out-of-range");
    apply_stimulus(wr(AW'(1010), 16'h0055, 2'b11), '0, g_a, g_b);
    apply_stimulus(rd(AW'(1010)), '0, g_a, g_b);
    check("oor_valid", a_rvalid1, 1'b1);
    check("oor_zero", a_rdata1, 16'h0000);
    apply_stimulus(rd(10'h000), '0, g_a, g_b);
    repeat (2) apply_stimulus('0, '0, g_a, g_b);

    $display("[TB] random traffic");
    pa = '0;
    pb = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa.req && ($urandom_range(0, 9) < 6)) begin
        ad = ($urandom_range(0, 9) == 0) ? AW'(990 + $urandom_range(0, 33)) : AW'($urandom_range(0, 47));
        pa = $urandom_range(0, 1) ? wr(ad, DW'($urandom), BW'($urandom)) : rd(ad);
      end
      if (!pb.req && ($urandom_range(0, 9) < 6)) begin
        ad = ($urandom_range(0, 9) == 0) ? AW'(990 + $urandom_range(0, 33)) : AW'($urandom_range(0, 47));
        pb = $urandom_range(0, 1) ? wr(ad, DW'($urandom), BW'($urandom)) : rd(ad);
      end
      apply_stimulus(pa, pb, g_a, g_b);
      if (g_a) pa = '0;
      if (g_b) pb = '0;
    end
    repeat (3) apply_stimulus('0, '0, g_a, g_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
